// File: rtl/shift_taps_pkg.sv
// Shared defaults and helpers for the tapped shift register.
// No logic of its own; imported by shift_taps_param and shift_tap_mux.
package shift_taps_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_NUM_TAPS = 4;

    // Evenly spaced tap positions used by the older fixed-tap version of this block.
    function automatic int legacy_tap_addr(input int k, input int depth, input int num_taps);
        return ((k + 1) * depth) / num_taps - 1;
    endfunction

endpackage

// File: rtl/shift_tap_mux.sv
// One tap: range check and stage select over the flop chain.
// Latency: combinational. Backpressure: none.
module shift_tap_mux
    import shift_taps_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] stage_dat,
    input  logic [DEPTH-1:0]            stage_vld,
    input  logic [$clog2(DEPTH):0]      addr,
    output logic [WIDTH-1:0]            tap_dat,
    output logic                        tap_vld,
    output logic                        addr_err
);

    localparam int AW = $clog2(DEPTH);

    // DEPTH is a power of two, so any address with the top bit set is out of range.
    assign addr_err = addr[AW];

    always_comb begin
        tap_dat = '0;
        tap_vld = 1'b0;
        if (!addr_err) begin
            tap_dat = stage_dat[addr[AW-1:0]];
            tap_vld = stage_vld[addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/shift_taps_param.sv
// Flop-based shift chain with valid bits, rotate mode, fill count and runtime taps.
// Latency: taps/sr_out combinational from state. Backpressure: none, shift is always accepted.
module shift_taps_param
    import shift_taps_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_TAPS = DEF_NUM_TAPS
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   shift,
    input  logic                                   rotate,
    input  logic                                   flush,
    input  logic [WIDTH-1:0]                       sr_in,
    input  logic [NUM_TAPS*($clog2(DEPTH)+1)-1:0]  tap_addr,
    output logic [WIDTH-1:0]                       sr_out,
    output logic                                   sr_out_valid,
    output logic [NUM_TAPS*WIDTH-1:0]              tap_data,
    output logic [NUM_TAPS-1:0]                    tap_valid,
    output logic [$clog2(DEPTH):0]                 fill_count,
    output logic                                   full,
    output logic                                   tap_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0]            vld_q;
    logic [AW:0]                 fill_q;
    logic                        tap_err_q;
    logic [NUM_TAPS-1:0]         tap_bad;

    logic [WIDTH-1:0] head_dat;
    logic             head_vld;

    // Rotate recirculates the tail word and its valid bit into stage 0.
    assign head_dat = rotate ? stage_q[DEPTH-1] : sr_in;
    assign head_vld = rotate ? vld_q[DEPTH-1]   : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= '0;
            vld_q     <= '0;
            fill_q    <= '0;
            tap_err_q <= 1'b0;
        end else begin
            if (flush) begin
                stage_q <= '0;
                vld_q   <= '0;
                fill_q  <= '0;
            end else if (shift) begin
                stage_q <= {stage_q[DEPTH-2:0], head_dat};
                vld_q   <= {vld_q[DEPTH-2:0], head_vld};
                if (!rotate && fill_q != FULL_CNT)
                    fill_q <= fill_q + 1'b1;
            end
            tap_err_q <= flush ? 1'b0 : (tap_err_q | (|tap_bad));
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        shift_tap_mux #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_tap (
            .stage_dat (stage_q),
            .stage_vld (vld_q),
            .addr      (tap_addr[k*(AW+1) +: AW+1]),
            .tap_dat   (tap_data[k*WIDTH +: WIDTH]),
            .tap_vld   (tap_valid[k]),
            .addr_err  (tap_bad[k])
        );
    end

    assign sr_out       = stage_q[DEPTH-1];
    assign sr_out_valid = vld_q[DEPTH-1];
    assign fill_count   = fill_q;
    assign full         = (fill_q == FULL_CNT);
    assign tap_err      = tap_err_q;

endmodule

// File: doc/shift_taps_param.md
SHIFT_TAPS_PARAM -- requirements
Module: shift_taps_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, SHALL be at least 1.
REQ-002 Parameter DEPTH, default 64: number of register stages, SHALL be a power of two and at least 2; AW = log2(DEPTH).
REQ-003 Parameter NUM_TAPS, default 4: number of runtime-addressable taps, SHALL be 1 to 8.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 shift  input  1  advance the chain by one stage this cycle.
REQ-007 rotate  input  1  circular mode: stage 0 SHALL load stage DEPTH-1 instead of sr_in.
REQ-008 flush  input  1  synchronous clear of data, valid bits and fill count.
REQ-009 sr_in  input  WIDTH  word entering stage 0.
REQ-010 tap_addr  input  NUM_TAPS*(AW+1)  per-tap stage index; tap k occupies bits [k*(AW+1) +: AW+1].
REQ-011 sr_out  output  WIDTH  contents of stage DEPTH-1.
REQ-012 sr_out_valid  output  1  valid bit of stage DEPTH-1.
REQ-013 tap_data  output  NUM_TAPS*WIDTH  tap k occupies bits [k*WIDTH +: WIDTH].
REQ-014 tap_valid  output  NUM_TAPS  valid bit of the stage selected by each tap.
REQ-015 fill_count  output  AW+1  number of valid stages, range 0 to DEPTH.
REQ-016 full  output  1  high when fill_count equals DEPTH.
REQ-017 tap_err  output  1  sticky flag set when any tap_addr is DEPTH or greater.

Function
REQ-018 Each stage SHALL carry one WIDTH data word and one valid bit.
REQ-019 Priority SHALL be flush, then shift, then hold; with none asserted, all state holds.
REQ-020 Shift with rotate=0: stage[n] <= stage[n-1] for n = 1 to DEPTH-1, stage[0] <= sr_in, valid[0] <= 1, and the word and valid bit of stage DEPTH-1 are discarded.
REQ-021 Shift with rotate=1: stage[0] <= stage[DEPTH-1] and valid[0] <= valid[DEPTH-1]; other stages as REQ-020; sr_in is ignored.
REQ-022 fill_count SHALL increment by 1 on a rotate=0 shift while below DEPTH, saturate at DEPTH, and stay unchanged on a rotate=1 shift.
REQ-023 Flush SHALL zero all data words, all valid bits and fill_count on the same edge, and overrides a simultaneous shift.
REQ-024 Taps SHALL be combinational from current state: tap_data[k] = stage[tap_addr[k]] and tap_valid[k] = valid[tap_addr[k]], with zero added latency.
REQ-025 For an out-of-range tap_addr[k] (DEPTH or greater), tap_data[k] SHALL be 0, tap_valid[k] SHALL be 0, and tap_err SHALL be set at the next edge.
REQ-026 tap_err SHALL be cleared only by reset or flush; flush clears it even if a bad address is still present, and it then re-sets on the following edge.
REQ-027 sr_out and sr_out_valid SHALL be combinational from stage DEPTH-1.
REQ-028 A word written at edge t SHALL appear on a tap addressed to stage j after exactly j+1 further shift edges (edge t included in the count); cycles without shift add no movement.

Reset
REQ-029 While rst_n=0, all data words, all valid bits, fill_count and tap_err SHALL be 0, independent of clk.
REQ-030 Consequently sr_out=0, sr_out_valid=0, full=0, and every tap_data and tap_valid reads 0.
REQ-031 Reset asserted mid-operation SHALL discard all contents; the first shift after release behaves as on an empty chain.

Structure
REQ-032 Package shift_taps_pkg SHALL hold the default WIDTH, DEPTH and NUM_TAPS values and a function that returns the legacy evenly spaced tap address ((k+1)*DEPTH/NUM_TAPS - 1).
REQ-033 One sub-module, shift_tap_mux, SHALL implement a single tap's range check and stage select; it is instantiated NUM_TAPS times.
REQ-034 Storage SHALL be flip-flops, not a RAM macro.

Verification (WIDTH=8, DEPTH=64, NUM_TAPS=4)
REQ-035 Reset then shift in 0x01..0x40 with rotate=0 -> sr_out=0x01, full=1, fill_count=64; legacy taps 15/31/47 read 0x31/0x21/0x11.
REQ-036 Empty chain, shift 0xAA once, then 5 idle cycles -> tap at address 0 reads 0xAA with valid=1; fill_count=1; tap at address 1 has valid=0.
REQ-037 Full chain, rotate=1 for 64 shifts -> contents identical to the start, fill_count=64, sr_in ignored.
REQ-038 shift=1 and flush=1 on the same cycle with 10 valid stages -> fill_count=0, all taps read 0, the sr_in word is not captured.
REQ-039 tap_addr[2]=64 -> tap_data[2]=0, tap_valid[2]=0, tap_err=1 the next cycle and held after the address is corrected, cleared by flush.
REQ-040 Drive rst_n low between clock edges after 30 shifts -> all outputs 0 immediately, without waiting for a clock edge; next shift of 0x55 gives fill_count=1.
